mux14to7_scan: RTL and testbench

//  Time-division display scanner: merges two 7-bit segment words (low digit, high digit) onto one

---
 rtl/mux14to7_scan_pkg.sv | 34 +++
 rtl/mux14to7_scan_timer.sv | 20 ++
 rtl/mux14to7_scan.sv | 116 +++++++++++
 tb/tb_mux14to7_scan.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/mux14to7_scan_pkg.sv
// Shared types and constants for the two-digit segment scanner.
package mux14to7_scan_pkg;

  localparam int unsigned SEG_W = 7;
  localparam int unsigned DIG_W = 2;

  typedef enum logic [1:0] {
    BLANK0 = 2'd0,
    SHOW0  = 2'd1,
    BLANK1 = 2'd2,
    SHOW1  = 2'd3
  } scan_state_e;

  localparam logic [DIG_W-1:0] DIG_NONE = 2'b00;
  localparam logic [DIG_W-1:0] DIG_LO   = 2'b01;
  localparam logic [DIG_W-1:0] DIG_HI   = 2'b10;

  // Pair of segment words (1 = lit) for the low and high digit.
  typedef struct packed {
    logic [SEG_W-1:0] hi;
    logic [SEG_W-1:0] lo;
  } seg_pair_t;

  // Bus value with every segment dark for the given polarity.
  function automatic logic [SEG_W-1:0] seg_blank(input bit active_low);
    return active_low ? {SEG_W{1'b1}} : {SEG_W{1'b0}};
  endfunction

  // Convert a lit-high segment word to bus polarity.
  function automatic logic [SEG_W-1:0] seg_drive(input logic [SEG_W-1:0] lit, input bit active_low);
    return active_low ? ~lit : lit;
  endfunction

endpackage

// File: rtl/mux14to7_scan_timer.sv
// Slot/blank counter with synchronous clear and terminal-count compare against a selectable limit.
module scan_timer #(
  parameter int unsigned DIV_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic [DIV_W-1:0] limit,
  output logic [DIV_W-1:0] cnt,
  output logic             tc_c
);

  always_ff @(posedge clk) begin
    if (rst || clr) cnt <= '0;
    else            cnt <= cnt + DIV_W'(1);
  end

  assign tc_c = (cnt == limit);

endmodule

// File: rtl/mux14to7_scan.sv
// Time-division scanner: two double-buffered segment words share one bus, with dead-time
// blanking between digit slots.
module mux14to7_scan
  import mux14to7_scan_pkg::*;
#(
  parameter int unsigned DIV_W          = 16,
  parameter int unsigned DIV_MAX        = 49999,
  parameter int unsigned BLANK_CYC      = 8,
  parameter int unsigned SEG_ACTIVE_LOW = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [SEG_W-1:0] in_lo,
  input  logic [SEG_W-1:0] in_hi,
  input  logic             load,
  input  logic             en,
  output logic [SEG_W-1:0] seg_out,
  output logic [DIG_W-1:0] dig_en,
  output logic             sel_out,
  output logic             frame_done
);

  localparam bit             ACT_LOW   = (SEG_ACTIVE_LOW != 0);
  localparam logic [SEG_W-1:0] SEG_BLANK = seg_blank(ACT_LOW);

  if ((64'(DIV_MAX) >> DIV_W) != 64'd0) begin : g_bad_div_max
    $error("DIV_MAX does not fit in DIV_W bits");
  end
  if (BLANK_CYC < 1 || (64'(BLANK_CYC) >> DIV_W) != 64'd0) begin : g_bad_blank_cyc
    $error("BLANK_CYC must be >= 1 and below 2**DIV_W");
  end

  scan_state_e      state, state_nxt;
  seg_pair_t        shadow, disp, disp_nxt;
  logic             pending;
  logic [DIV_W-1:0] cnt, cnt_nxt, limit;
  logic             tc_c, clr, xfer;

  scan_timer #(.DIV_W(DIV_W)) u_timer (
    .clk  (clk),
    .rst  (rst),
    .clr  (clr),
    .limit(limit),
    .cnt  (cnt),
    .tc_c (tc_c)
  );

  // Next state, counter preview and the double-buffer transfer decision.
  always_comb begin
    limit     = (state == SHOW0 || state == SHOW1) ? DIV_W'(DIV_MAX) : DIV_W'(BLANK_CYC - 1);
    state_nxt = state;
    if (!en) begin
      state_nxt = BLANK0;
    end else if (tc_c) begin
      case (state)
        BLANK0:  state_nxt = SHOW0;
        SHOW0:   state_nxt = BLANK1;
        BLANK1:  state_nxt = SHOW1;
        default: state_nxt = BLANK0;
      endcase
    end
    clr     = !en || tc_c;
    cnt_nxt = clr ? '0 : cnt + DIV_W'(1);
    // Transfer only at frame boundaries (natural or forced), so disp never changes mid-frame.
    xfer     = !en || (state == SHOW1 && tc_c);
    disp_nxt = disp;
    if (xfer) begin
      if (load)         disp_nxt = '{hi: in_hi, lo: in_lo};
      else if (pending) disp_nxt = shadow;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= BLANK0;
      shadow     <= '0;
      disp       <= '0;
      pending    <= 1'b0;
      seg_out    <= SEG_BLANK;
      dig_en     <= DIG_NONE;
      sel_out    <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      state <= state_nxt;
      disp  <= disp_nxt;
      if (load) shadow <= '{hi: in_hi, lo: in_lo};
      if (xfer)      pending <= 1'b0;
      else if (load) pending <= 1'b1;
      // Outputs follow the state being entered so they switch on the same edge.
      case (state_nxt)
        SHOW0: begin
          seg_out <= seg_drive(disp_nxt.lo, ACT_LOW);
          dig_en  <= DIG_LO;
          sel_out <= 1'b0;
        end
        BLANK1: begin
          seg_out <= SEG_BLANK;
          dig_en  <= DIG_NONE;
          sel_out <= 1'b1;
        end
        SHOW1: begin
          seg_out <= seg_drive(disp_nxt.hi, ACT_LOW);
          dig_en  <= DIG_HI;
          sel_out <= 1'b1;
        end
        default: begin
          seg_out <= SEG_BLANK;
          dig_en  <= DIG_NONE;
          sel_out <= 1'b0;
        end
      endcase
      frame_done <= en && (state_nxt == SHOW1) && (cnt_nxt == DIV_W'(DIV_MAX));
    end
  end

endmodule

// File: tb/tb_mux14to7_scan.sv
// Bench for mux14to7_scan: directed table, corner-case sequences and random traffic
// against a frame-position reference model (12-cycle frame).
module tb_mux14to7_scan;

  localparam int unsigned DIV_W     = 16;
  localparam int unsigned DIV_MAX   = 3;
  localparam int unsigned BLANK_CYC = 2;
  localparam int          FRAME     = 2 * (BLANK_CYC + DIV_MAX + 1);

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [6:0] in_lo = '0;
  logic [6:0] in_hi = '0;
  logic       load = 1'b0;
  logic       en = 1'b1;
  logic [6:0] seg_out;
  logic [1:0] dig_en;
  logic       sel_out;
  logic       frame_done;

  int vectors = 0;
  int miscompares = 0;

  mux14to7_scan #(
    .DIV_W(DIV_W), .DIV_MAX(DIV_MAX), .BLANK_CYC(BLANK_CYC), .SEG_ACTIVE_LOW(1)
  ) dut (
    .clk(clk), .rst(rst), .in_lo(in_lo), .in_hi(in_hi), .load(load), .en(en),
    .seg_out(seg_out), .dig_en(dig_en), .sel_out(sel_out), .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  // Reference model: position within the frame plus the two buffers.
  int         m_pos = 0;
  logic [6:0] m_disp_lo = '0, m_disp_hi = '0, m_sh_lo = '0, m_sh_hi = '0;
  logic       m_pend = 1'b0;

  task automatic chk(input string nm, input logic [6:0] act, input logic [6:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic model_transfer();
    if (load) begin
      m_disp_lo = in_lo; m_disp_hi = in_hi;
      m_sh_lo = in_lo;   m_sh_hi = in_hi;
      m_pend = 1'b0;
    end else if (m_pend) begin
      m_disp_lo = m_sh_lo; m_disp_hi = m_sh_hi;
      m_pend = 1'b0;
    end
  endtask

  task automatic model_edge();
    if (rst) begin
      m_pos = 0; m_pend = 1'b0;
      m_disp_lo = '0; m_disp_hi = '0; m_sh_lo = '0; m_sh_hi = '0;
    end else if (!en || m_pos == FRAME - 1) begin
      m_pos = 0;
      model_transfer();
    end else begin
      m_pos++;
      if (load) begin
        m_sh_lo = in_lo; m_sh_hi = in_hi; m_pend = 1'b1;
      end
    end
  endtask

  // One clock: update model with the sampled inputs, then compare all outputs.
  task automatic step();
    logic [6:0] e_seg;
    logic [1:0] e_dig;
    @(posedge clk);
    model_edge();
    #1;
    e_seg = 7'h7F; e_dig = 2'b00;
    if (m_pos >= 2 && m_pos <= 5) begin e_seg = ~m_disp_lo; e_dig = 2'b01; end
    if (m_pos >= 8)               begin e_seg = ~m_disp_hi; e_dig = 2'b10; end
    chk("seg_out", seg_out, e_seg);
    chk("dig_en", 7'(dig_en), 7'(e_dig));
    chk("sel_out", 7'(sel_out), 7'(m_pos >= 6));
    chk("frame_done", 7'(frame_done), 7'(m_pos == FRAME - 1));
  endtask

  task automatic run_to(input int p);
    int n;
    load = 1'b0;
    n = 0;
    while (m_pos != p && n < 3 * FRAME) begin
      step();
      n++;
    end
    vectors++;
    if (m_pos != p) begin
      miscompares++;
      $display("FAIL run_to: position %0d expected %0d", m_pos, p);
    end
  endtask

  typedef struct {
    logic       rst, en, load;
    logic [6:0] lo, hi;
    logic [6:0] seg;
    logic [1:0] dig;
    logic       sel, fd;
  } vec_t;

  function automatic vec_t mk(input logic r, input logic e, input logic l, input logic [6:0] lo,
                              input logic [6:0] hi, input logic [6:0] seg, input logic [1:0] dig,
                              input logic sel, input logic fd);
    vec_t v;
    v.rst = r; v.en = e; v.load = l; v.lo = lo; v.hi = hi;
    v.seg = seg; v.dig = dig; v.sel = sel; v.fd = fd;
    return v;
  endfunction

  vec_t tbl[22];
  int   pulses;

  initial begin
    // Reset, first frame with a mid-SHOW0 load, then the frame that shows it.
    tbl[0]  = mk(1, 1, 0, 0, 0, 7'h7F, 2'b00, 0, 0);
    tbl[1]  = mk(1, 1, 0, 0, 0, 7'h7F, 2'b00, 0, 0);
    tbl[2]  = mk(0, 1, 0, 0, 0, 7'h7F, 2'b00, 0, 0);
    tbl[3]  = mk(0, 1, 0, 0, 0, 7'h7F, 2'b01, 0, 0);
    tbl[4]  = mk(0, 1, 1, 7'h06, 7'h5B, 7'h7F, 2'b01, 0, 0);
    tbl[5]  = mk(0, 1, 0, 0, 0, 7'h7F, 2'b01, 0, 0);
    tbl[6]  = mk(0, 1, 0, 0, 0, 7'h7F, 2'b01, 0, 0);
    tbl[7]  = mk(0, 1, 0, 0, 0, 7'h7F, 2'b00, 1, 0);
    tbl[8]  = mk(0, 1, 0, 0, 0, 7'h7F, 2'b00, 1, 0);
    tbl[9]  = mk(0, 1, 0, 0, 0, 7'h7F, 2'b10, 1, 0);
    tbl[10] = mk(0, 1, 0, 0, 0, 7'h7F, 2'b10, 1, 0);
    tbl[11] = mk(0, 1, 0, 0, 0, 7'h7F, 2'b10, 1, 0);
    tbl[12] = mk(0, 1, 0, 0, 0, 7'h7F, 2'b10, 1, 1);
    tbl[13] = mk(0, 1, 0, 0, 0, 7'h7F, 2'b00, 0, 0);
    tbl[14] = mk(0, 1, 0, 0, 0, 7'h7F, 2'b00, 0, 0);
    tbl[15] = mk(0, 1, 0, 0, 0, 7'h79, 2'b01, 0, 0);
    tbl[16] = mk(0, 1, 0, 0, 0, 7'h79, 2'b01, 0, 0);
    tbl[17] = mk(0, 1, 0, 0, 0, 7'h79, 2'b01, 0, 0);
    tbl[18] = mk(0, 1, 0, 0, 0, 7'h79, 2'b01, 0, 0);
    tbl[19] = mk(0, 1, 0, 0, 0, 7'h7F, 2'b00, 1, 0);
    tbl[20] = mk(0, 1, 0, 0, 0, 7'h7F, 2'b00, 1, 0);
    tbl[21] = mk(0, 1, 0, 0, 0, 7'h24, 2'b10, 1, 0);

    for (int i = 0; i < 22; i++) begin
      rst = tbl[i].rst; en = tbl[i].en; load = tbl[i].load;
      in_lo = tbl[i].lo; in_hi = tbl[i].hi;
      step();
      chk("tbl_seg", seg_out, tbl[i].seg);
      chk("tbl_dig", 7'(dig_en), 7'(tbl[i].dig));
      chk("tbl_sel", 7'(sel_out), 7'(tbl[i].sel));
      chk("tbl_fd", 7'(frame_done), 7'(tbl[i].fd));
    end
    load = 1'b0;

    // Exactly one frame_done pulse per 12-cycle frame.
    pulses = 0;
    for (int i = 0; i < 3 * FRAME; i++) begin
      step();
      if (frame_done === 1'b1) pulses++;
    end
    chk("fd_pulses", 7'(pulses), 7'd3);

    // Two loads in one frame: last one wins.
    run_to(3);
    in_lo = 7'h3F; in_hi = 7'h5B; load = 1'b1; step();
    run_to(5);
    in_lo = 7'h66; load = 1'b1; step();
    run_to(2);
    chk("last_load_wins", seg_out, 7'h19);
    run_to(8);
    chk("hi_kept", seg_out, 7'h24);

    // Load on the transfer edge bypasses shadow and leaves nothing pending.
    run_to(4);
    in_lo = 7'h01; in_hi = 7'h01; load = 1'b1; step();
    run_to(FRAME - 1);
    in_lo = 7'h7F; in_hi = 7'h7F; load = 1'b1; step();
    run_to(2);
    chk("bypass_lo", seg_out, 7'h00);
    run_to(8);
    chk("bypass_hi", seg_out, 7'h00);
    run_to(2);
    chk("no_stale_pending", seg_out, 7'h00);

    // en=0 mid SHOW1 blanks at once; restart begins with a full BLANK0.
    run_to(9);
    en = 1'b0; step();
    chk("dis_seg", seg_out, 7'h7F);
    chk("dis_dig", 7'(dig_en), 7'd0);
    chk("dis_fd", 7'(frame_done), 7'd0);
    step();
    en = 1'b1; step();
    chk("restart_blank", 7'(dig_en), 7'd0);
    step();
    chk("restart_show", 7'(dig_en), 7'd1);

    // Reset mid SHOW0 with pending data drops both buffers.
    run_to(3);
    in_lo = 7'h11; in_hi = 7'h22; load = 1'b1; step();
    load = 1'b0; rst = 1'b1; step();
    chk("rst_seg", seg_out, 7'h7F);
    chk("rst_dig", 7'(dig_en), 7'd0);
    chk("rst_sel", 7'(sel_out), 7'd0);
    rst = 1'b0;
    run_to(2);
    chk("rst_disp_cleared", seg_out, 7'h7F);
    run_to(FRAME - 1);
    run_to(2);
    chk("rst_pending_dropped", seg_out, 7'h7F);

    // Random traffic against the model.
    for (int i = 0; i < 500; i++) begin
      rst   = ($urandom_range(0, 99) == 0);
      en    = ($urandom_range(0, 19) != 0);
      load  = ($urandom_range(0, 5) == 0);
      in_lo = 7'($urandom);
      in_hi = 7'($urandom);
      step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
